pe_iact_spad_fill: RTL and testbench

Per-PE input-activation scratchpad fill stage, directly downstream of the PE-cluster iact fan-out network. It accepts one compressed iact vector pair per load:
- a CSC address stream (8-bit beats);
- a data stream (13-bit beats).

Both streams are valid-only, with no backpressure. The block stores them into an address SPad and a data SPad, detects end-of-vector, and exposes registered read ports to the PE MAC datapath.

---
 rtl/iact_spad_pkg.sv | 18 +
 rtl/iact_spad_stream_writer.sv | 88 ++++++++
 rtl/pe_iact_spad_fill.sv | 116 +++++++++++
 tb/tb_pe_iact_spad_fill.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/iact_spad_pkg.sv
// Shared widths, depths, terminator codes and FSM state type for the iact SPad fill stage.
package iact_spad_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 13;
  localparam int unsigned ADDR_DEPTH = 9;
  localparam int unsigned DATA_DEPTH = 16;

  localparam logic [ADDR_W-1:0] ADDR_TERM = 8'h00;
  localparam logic [DATA_W-1:0] DATA_TERM = 13'h0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } fill_state_e;

endpackage

// File: rtl/iact_spad_stream_writer.sv
// One SPad stream: appends valid beats, detects the terminator, flags overflow and
// provides a registered read port. Instantiated once for addresses and once for data.
module iact_spad_stream_writer
  import iact_spad_pkg::*;
#(
  parameter int unsigned W                = 8,
  parameter int unsigned DEPTH            = 9,
  parameter logic [W-1:0] TERM            = '0,
  // When set, a TERM beat at pointer 0 is stored as data instead of terminating.
  parameter bit          TERM_NEEDS_ENTRY = 1'b0,
  localparam int unsigned IDX_W           = $clog2(DEPTH),
  localparam int unsigned PTR_W           = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [W-1:0]     i_bits,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [PTR_W-1:0] o_ptr,
  output logic             o_term,
  output logic             o_overflow,
  output logic [W-1:0]     o_rd_data
);

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic             r_term;
  logic             r_overflow;
  logic [W-1:0]     r_rd_data;

  logic             w_accept;
  logic             w_is_term;
  logic             w_full;
  logic             w_write;
  logic [W-1:0]     w_rd_word;

  assign w_accept  = i_valid & i_enable & ~i_clear & ~r_term;
  assign w_is_term = (i_bits == TERM) & (~TERM_NEEDS_ENTRY | (r_ptr != '0));
  assign w_full    = (r_ptr == DEPTH_P);
  assign w_write   = w_accept & ~w_is_term & ~w_full;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_ptr      <= '0;
      r_term     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      if (w_is_term) begin
        r_term <= 1'b1;
      end else if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_ptr[IDX_W-1:0]] <= i_bits;
    end
  end

  if (DEPTH == (1 << IDX_W)) begin : g_rd_full
    assign w_rd_word = r_mem[i_rd_idx];
  end else begin : g_rd_guarded
    assign w_rd_word = (i_rd_idx < IDX_W'(DEPTH)) ? r_mem[i_rd_idx] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_word;
    end
  end

  assign o_ptr      = r_ptr;
  assign o_term     = r_term;
  assign o_overflow = r_overflow;
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/pe_iact_spad_fill.sv
// Per-PE iact SPad fill stage: fills the address and data SPads from the fan-out streams.
// Optional IACT_SPAD_COUNT_EN exposes the stored-entry counts as addr_count / data_count.
module pe_iact_spad_fill
  import iact_spad_pkg::*;
#(
  parameter int unsigned ADDR_W     = iact_spad_pkg::ADDR_W,
  parameter int unsigned DATA_W     = iact_spad_pkg::DATA_W,
  parameter int unsigned ADDR_DEPTH = iact_spad_pkg::ADDR_DEPTH,
  parameter int unsigned DATA_DEPTH = iact_spad_pkg::DATA_DEPTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            load_start,
  input  logic                            address_in_valid,
  input  logic [ADDR_W-1:0]               address_in_bits,
  input  logic                            data_in_valid,
  input  logic [DATA_W-1:0]               data_in_bits,
  input  logic [$clog2(ADDR_DEPTH)-1:0]   rd_addr_idx,
  input  logic [$clog2(DATA_DEPTH)-1:0]   rd_data_idx,
  output logic [ADDR_W-1:0]               rd_addr_out,
  output logic [DATA_W-1:0]               rd_data_out,
  output logic                            filling,
  output logic                            fill_done,
`ifdef IACT_SPAD_COUNT_EN
  output logic [$clog2(ADDR_DEPTH+1)-1:0] addr_count,
  output logic [$clog2(DATA_DEPTH+1)-1:0] data_count,
`endif
  output logic                            overflow_err
);

  fill_state_e r_state;
  fill_state_e w_state_next;

  logic                            w_fill_en;
  logic                            w_addr_term;
  logic                            w_data_term;
  logic                            w_addr_ovf;
  logic                            w_data_ovf;
  logic [$clog2(ADDR_DEPTH+1)-1:0] w_addr_ptr;
  logic [$clog2(DATA_DEPTH+1)-1:0] w_data_ptr;

  assign w_fill_en = (r_state == StFill);

  iact_spad_stream_writer #(
    .W                (ADDR_W),
    .DEPTH            (ADDR_DEPTH),
    .TERM             (ADDR_W'(ADDR_TERM)),
    .TERM_NEEDS_ENTRY (1'b1)
  ) u_addr_writer (
    .clock      (clock),
    .reset      (reset),
    .i_valid    (address_in_valid),
    .i_bits     (address_in_bits),
    .i_enable   (w_fill_en),
    .i_clear    (load_start),
    .i_rd_idx   (rd_addr_idx),
    .o_ptr      (w_addr_ptr),
    .o_term     (w_addr_term),
    .o_overflow (w_addr_ovf),
    .o_rd_data  (rd_addr_out)
  );

  iact_spad_stream_writer #(
    .W                (DATA_W),
    .DEPTH            (DATA_DEPTH),
    .TERM             (DATA_W'(DATA_TERM)),
    .TERM_NEEDS_ENTRY (1'b0)
  ) u_data_writer (
    .clock      (clock),
    .reset      (reset),
    .i_valid    (data_in_valid),
    .i_bits     (data_in_bits),
    .i_enable   (w_fill_en),
    .i_clear    (load_start),
    .i_rd_idx   (rd_data_idx),
    .o_ptr      (w_data_ptr),
    .o_term     (w_data_term),
    .o_overflow (w_data_ovf),
    .o_rd_data  (rd_data_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DONE follows one cycle after both registered terminator flags are visible.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: w_state_next = StIdle;
      StFill: if (w_addr_term && w_data_term) w_state_next = StDone;
      StDone: w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
    if (load_start) begin
      w_state_next = StFill;
    end
  end

  assign filling      = (r_state == StFill);
  assign fill_done    = (r_state == StDone);
  assign overflow_err = w_addr_ovf | w_data_ovf;

`ifdef IACT_SPAD_COUNT_EN
  assign addr_count = w_addr_ptr;
  assign data_count = w_data_ptr;
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^{w_addr_ptr, w_data_ptr};
`endif

endmodule

// File: tb/tb_pe_iact_spad_fill.sv
// Directed self-checking bench for pe_iact_spad_fill (count checks under IACT_SPAD_COUNT_EN).
module tb_pe_iact_spad_fill;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic        address_in_valid;
  logic [7:0]  address_in_bits;
  logic        data_in_valid;
  logic [12:0] data_in_bits;
  logic [3:0]  rd_addr_idx;
  logic [3:0]  rd_data_idx;
  logic [7:0]  rd_addr_out;
  logic [12:0] rd_data_out;
  logic        filling;
  logic        fill_done;
  logic        overflow_err;
`ifdef IACT_SPAD_COUNT_EN
  logic [3:0]  addr_count;
  logic [4:0]  data_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  pe_iact_spad_fill u_dut (
    .clock            (clock),
    .reset            (reset),
    .load_start       (load_start),
    .address_in_valid (address_in_valid),
    .address_in_bits  (address_in_bits),
    .data_in_valid    (data_in_valid),
    .data_in_bits     (data_in_bits),
    .rd_addr_idx      (rd_addr_idx),
    .rd_data_idx      (rd_data_idx),
    .rd_addr_out      (rd_addr_out),
    .rd_data_out      (rd_data_out),
    .filling          (filling),
    .fill_done        (fill_done),
`ifdef IACT_SPAD_COUNT_EN
    .addr_count       (addr_count),
    .data_count       (data_count),
`endif
    .overflow_err     (overflow_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic av, input logic [7:0] a, input logic dv, input logic [12:0] d);
    address_in_valid = av;
    address_in_bits  = a;
    data_in_valid    = dv;
    data_in_bits     = d;
    tick();
    address_in_valid = 1'b0;
    data_in_valid    = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic rd(input logic [3:0] ai, input logic [3:0] di);
    rd_addr_idx = ai;
    rd_data_idx = di;
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    load_start       = 1'b0;
    address_in_valid = 1'b0;
    address_in_bits  = '0;
    data_in_valid    = 1'b0;
    data_in_bits     = '0;
    rd_addr_idx      = '0;
    rd_data_idx      = '0;
    tick();
    tick();
    check_eq("rst_filling", filling, 0);
    check_eq("rst_done", fill_done, 0);
    check_eq("rst_ovf", overflow_err, 0);
    check_eq("rst_rd_addr", rd_addr_out, 0);
    check_eq("rst_rd_data", rd_data_out, 0);
    reset = 1'b0;

    // Beats while IDLE are dropped.
    beat(1'b1, 8'd3, 1'b1, 13'h0011);
    beat(1'b1, 8'd0, 1'b1, 13'h0000);
    beat(1'b1, 8'd9, 1'b1, 13'h0022);
    check_eq("idle_filling", filling, 0);
    check_eq("idle_done", fill_done, 0);
    check_eq("idle_ovf", overflow_err, 0);

    // Basic vector; beats alongside load_start are ignored.
    load_start = 1'b1;
    beat(1'b1, 8'd9, 1'b1, 13'h0999);
    load_start = 1'b0;
    check_eq("v1_filling", filling, 1);
    beat(1'b1, 8'd3, 1'b1, 13'h0101);
    beat(1'b1, 8'd5, 1'b0, 13'h0000);
    beat(1'b0, 8'd0, 1'b1, 13'h0202);
    beat(1'b1, 8'd8, 1'b1, 13'h0303);
    beat(1'b0, 8'd0, 1'b1, 13'h0000);
    check_eq("v1_dterm_filling", filling, 1);
    check_eq("v1_dterm_done", fill_done, 0);
    beat(1'b1, 8'd0, 1'b0, 13'h0000);
    check_eq("v1_aterm_done", fill_done, 0);
    tick();
    check_eq("v1_done", fill_done, 1);
    check_eq("v1_done_filling", filling, 0);
`ifdef IACT_SPAD_COUNT_EN
    check_eq("v1_addr_count", addr_count, 3);
    check_eq("v1_data_count", data_count, 3);
`endif
    rd(4'd1, 4'd2);
    check_eq("v1_rd_addr1", rd_addr_out, 8'd5);
    check_eq("v1_rd_data2", rd_data_out, 13'h0303);
    rd(4'd0, 4'd0);
    check_eq("v1_rd_addr0", rd_addr_out, 8'd3);
    check_eq("v1_rd_data0", rd_data_out, 13'h0101);
    rd(4'd9, 4'd1);
    check_eq("v1_rd_addr_oob", rd_addr_out, 8'd0);
    check_eq("v1_rd_data1", rd_data_out, 13'h0202);
    beat(1'b1, 8'd7, 1'b1, 13'h0077);
    check_eq("v1_done_hold", fill_done, 1);
    check_eq("v1_done_ovf", overflow_err, 0);
`ifdef IACT_SPAD_COUNT_EN
    check_eq("v1_done_addr_count", addr_count, 3);
`endif
    rd(4'd0, 4'd0);
    check_eq("v1_done_drop", rd_addr_out, 8'd3);

    // Both terminators in the same cycle.
    start_load();
    beat(1'b1, 8'd1, 1'b1, 13'h0001);
    beat(1'b1, 8'd2, 1'b1, 13'h0002);
    beat(1'b0, 8'd0, 1'b1, 13'h0003);
    beat(1'b0, 8'd0, 1'b1, 13'h0004);
    beat(1'b1, 8'd0, 1'b1, 13'h0000);
    check_eq("v2_term_done", fill_done, 0);
    tick();
    check_eq("v2_done", fill_done, 1);
`ifdef IACT_SPAD_COUNT_EN
    check_eq("v2_addr_count", addr_count, 2);
    check_eq("v2_data_count", data_count, 4);
`endif
    rd(4'd1, 4'd3);
    check_eq("v2_rd_addr1", rd_addr_out, 8'd2);
    check_eq("v2_rd_data3", rd_data_out, 13'h0004);

    // Data overflow: 17 beats into 16 entries.
    start_load();
    beat(1'b1, 8'd6, 1'b0, 13'h0000);
    for (int i = 0; i < 17; i++) begin
      beat(1'b0, 8'd0, 1'b1, 13'(32'h100 + i));
      if (i == 15) check_eq("v3_ovf_at16", overflow_err, 0);
    end
    check_eq("v3_ovf_at17", overflow_err, 1);
    beat(1'b0, 8'd0, 1'b1, 13'h0000);
    tick();
    check_eq("v3_wait_aterm", filling, 1);
    check_eq("v3_ovf_sticky", overflow_err, 1);
    beat(1'b1, 8'd0, 1'b0, 13'h0000);
    tick();
    check_eq("v3_done", fill_done, 1);
    check_eq("v3_done_ovf", overflow_err, 1);
`ifdef IACT_SPAD_COUNT_EN
    check_eq("v3_data_count", data_count, 16);
`endif
    rd(4'd0, 4'd15);
    check_eq("v3_rd_data15", rd_data_out, 13'h010F);
    check_eq("v3_rd_addr0", rd_addr_out, 8'd6);

    // load_start clears overflow, then restarts a partial fill.
    start_load();
    check_eq("v4_ovf_cleared", overflow_err, 0);
    check_eq("v4_filling", filling, 1);
    beat(1'b1, 8'h11, 1'b1, 13'h0021);
    beat(1'b1, 8'h12, 1'b1, 13'h0022);
    start_load();
    check_eq("v4_restart_filling", filling, 1);
    check_eq("v4_restart_ovf", overflow_err, 0);
`ifdef IACT_SPAD_COUNT_EN
    check_eq("v4_restart_addr_count", addr_count, 0);
    check_eq("v4_restart_data_count", data_count, 0);
`endif
    beat(1'b1, 8'd7, 1'b1, 13'h0055);
    beat(1'b1, 8'd0, 1'b1, 13'h0000);
    tick();
    check_eq("v4_done", fill_done, 1);
    rd(4'd0, 4'd0);
    check_eq("v4_rd_addr0", rd_addr_out, 8'd7);
    check_eq("v4_rd_data0", rd_data_out, 13'h0055);

    // Leading zero address beat is stored as an empty first column.
    start_load();
    beat(1'b1, 8'd0, 1'b1, 13'h0005);
    check_eq("v5_zero_first_filling", filling, 1);
    beat(1'b1, 8'd4, 1'b0, 13'h0000);
    beat(1'b1, 8'd0, 1'b1, 13'h0000);
    check_eq("v5_term_done", fill_done, 0);
    tick();
    check_eq("v5_done", fill_done, 1);
`ifdef IACT_SPAD_COUNT_EN
    check_eq("v5_addr_count", addr_count, 2);
`endif
    rd(4'd0, 4'd0);
    check_eq("v5_rd_addr0", rd_addr_out, 8'd0);
    check_eq("v5_rd_data0", rd_data_out, 13'h0005);
    rd(4'd1, 4'd0);
    check_eq("v5_rd_addr1", rd_addr_out, 8'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
